move_cmd_queue: RTL and testbench
=================================

# move_cmd_queue

Downstream stage of the keyboard input block: converts the level-style `up`/`down`/`left`/`right`/`Enter` key-held signals into single move commands, one per key press. Commands are buffered in a small FIFO and handed to the 2048 game engine over a valid/ready handshake. The FIFO lets key presses that arrive while the engine is still sliding or merging tiles be queued instead of lost.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `up`, `down`, `left`, `right`, `Enter`  in  1 each  key-held levels, synchronous to `clk`.
- `flush`  in  1  synchronous clear of all queued commands (new game / game over).
- `cmd_ready`  in  1  game engine accepts the head command.
- `cmd_valid`  out  1  head command present.
- `cmd`  out  3  head command: 0=up, 1=down, 2=left, 3=right, 4=enter; values 5-7 never produced.
- `count`  out  $clog2(DEPTH)+1  number of queued commands, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse when a detected press is dropped.

## Operation
- Edge detect:
  - A 5-bit `prev` register holds the last sampled levels.
  - rise[i] = level[i] & ~prev[i].
  - `prev` loads the current levels every cycle.
- Reset value of `prev` is all-ones: a key held through reset release generates no command until it is released and pressed again.
- Simultaneous rises in one cycle:
  - Only one command is generated, by fixed priority up > down > left > right > Enter.
  - The other rises are discarded silently; they do not assert `overflow`.
- Push: a rise pushes its encoded command into the FIFO tail.
- Pop: occurs when `cmd_valid & cmd_ready`; the head advances.
- Full FIFO (`count == DEPTH`):
  - With a push and no pop in the same cycle, the command is dropped and `overflow` pulses for 1 cycle.
  - With a push and a pop in the same cycle, the push is accepted and `count` stays at DEPTH.
- Empty FIFO: `cmd_valid = 0`, and `cmd` holds its last value (don't-care). There is no combinational bypass from keys to `cmd`.
- `flush`:
  - Clears the pointers and `count` to 0 on that edge.
  - Any push or pop in the same cycle is ignored.
  - `overflow` stays 0.
  - `prev` still updates normally.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` increments on push only, decrements on pop only, and is unchanged on push+pop.
- Reset (async, any time, including mid-handshake):
  - `count=0`, pointers `0`, `cmd_valid=0`, `cmd=0`, `overflow=0`, `prev=5'b11111`.
  - FIFO storage contents are not reset.

## Timing
- Latency:
  - Key level first sampled high at edge N is pushed at edge N.
  - `cmd_valid` is high from N+1 when the FIFO was empty.
- Handshake:
  - `cmd` is stable while `cmd_valid=1` and `cmd_ready=0`.
  - `cmd_ready` may be held high permanently; throughput is then 1 command per cycle.
- `cmd_valid` depends only on registers; there is no combinational path from `cmd_ready` to `cmd_valid` or `cmd`.
- `overflow` is registered and asserts in the cycle after the dropping edge.
- A held key produces exactly one command, regardless of hold length. There is no auto-repeat.

## Test plan
- **Reset/held key:** hold `left=1` across `rst` deassert for 10 cycles → no command. Release 1 cycle, press again → `cmd=2` valid 1 cycle after the press edge, `count=1`.
- **Single press and handshake:** pulse `up` for 1 cycle with `cmd_ready=0` → `cmd_valid=1`, `cmd=0` held for 20 cycles. Raise `cmd_ready` for 1 cycle → `cmd_valid=0`, `count=0`.
- **Priority:** `down`, `right`, `Enter` rise on the same edge → exactly one entry, `cmd=1`, `overflow` stays 0.
- **Full/overflow with DEPTH=4:** with `cmd_ready=0`, apply 5 separate presses up, down, left, right, Enter → `count=4`, one `overflow` pulse on the 5th press. Draining yields 0, 1, 2, 3.
- **Full with simultaneous pop:** queue full, `cmd_ready=1` on the same edge as a new `Enter` press → `count` stays 4, no overflow, and `Enter` (4) is popped last.
- **Flush and wrap:** queue 3 commands, assert `flush` together with `cmd_ready` and a press → `count=0`, `cmd_valid=0` next cycle. Then run 10 press/pop pairs → pointers wrap and the commands are returned in press order.

Source files
------------

// File: rtl/move_cmd_queue.sv
`default_nettype none
// ============================================================================
// move_cmd_queue : key-press edge detector feeding a small command FIFO
// Revision: 1.0
// ============================================================================
module move_cmd_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     up,
   input  logic                     down,
   input  logic                     left,
   input  logic                     right,
   input  logic                     Enter,
   input  logic                     flush,
   input  logic                     cmd_ready,
   output logic                     cmd_valid,
   output logic [2:0]               cmd,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = c_aw + 1;

   logic [4:0]      w_lvl;
   logic [4:0]      w_rise;
   logic [4:0]      r_prev;
   logic [2:0]      w_code;
   logic            w_press;
   logic            w_full;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic [c_aw-1:0] r_wr;
   logic [c_aw-1:0] r_rd;
   logic [c_aw-1:0] w_rd_nxt;
   logic [c_cw-1:0] r_count;
   logic [c_cw-1:0] w_remain;
   logic [c_cw-1:0] w_count_nxt;
   logic [2:0]      w_head_nxt;
   logic [2:0]      r_cmd;
   logic            r_ovf;
   logic [2:0]      r_mem [DEPTH];

   assign w_lvl  = {Enter, right, left, down, up};
   assign w_rise = w_lvl & ~r_prev;

   always_comb begin
      w_code  = 3'd0;
      w_press = |w_rise;
      if (w_rise[0])      w_code = 3'd0;
      else if (w_rise[1]) w_code = 3'd1;
      else if (w_rise[2]) w_code = 3'd2;
      else if (w_rise[3]) w_code = 3'd3;
      else if (w_rise[4]) w_code = 3'd4;
   end

   assign w_full      = (r_count == c_cw'(DEPTH));
   assign w_pop       = (r_count != '0) & cmd_ready;
   assign w_push      = w_press & (~w_full | w_pop);
   assign w_drop      = w_press & w_full & ~w_pop & ~flush;
   assign w_rd_nxt    = w_pop ? r_rd + c_aw'(1) : r_rd;
   assign w_remain    = r_count - c_cw'(w_pop);
   assign w_count_nxt = w_remain + c_cw'(w_push);
   // If nothing older survives this edge, the new head is the command being pushed now.
   assign w_head_nxt  = (w_remain == '0) ? w_code : r_mem[w_rd_nxt];

   always_ff @(posedge clk) begin
      if (w_push && !flush) r_mem[r_wr] <= w_code;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev  <= 5'b11111;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_cmd   <= 3'd0;
         r_ovf   <= 1'b0;
      end else begin
         r_prev <= w_lvl;
         if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
         end else begin
            if (w_push) r_wr <= r_wr + c_aw'(1);
            r_rd    <= w_rd_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_drop;
            // Output holds its last value while the queue is empty.
            if (w_count_nxt != '0) r_cmd <= w_head_nxt;
         end
      end
   end

   assign cmd_valid = (r_count != '0);
   assign cmd       = r_cmd;
   assign count     = r_count;
   assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_move_cmd_queue.sv
`default_nettype none
// ============================================================================
// tb_move_cmd_queue : directed scoreboard bench for move_cmd_queue (DEPTH=4)
// Revision: 1.0
// ============================================================================
module tb_move_cmd_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] keys;
   logic       flush;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic [2:0] count;
   logic       overflow;

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   move_cmd_queue #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .up        (keys[0]),
      .down      (keys[1]),
      .left      (keys[2]),
      .right     (keys[3]),
      .Enter     (keys[4]),
      .flush     (flush),
      .cmd_ready (cmd_ready),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .count     (count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle press of key k; expected command is queued when accepted.
   task automatic press(input int k, input bit accepted);
      keys[k] = 1'b1;
      if (accepted) exp_q.push_back(k);
      tick();
      keys[k] = 1'b0;
   endtask

   task automatic drain(input int n);
      cmd_ready = 1'b1;
      repeat (n) tick();
      cmd_ready = 1'b0;
   endtask

   // Monitor: a handshake completes on the coming edge; compare against scoreboard.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         if (rst && cmd_valid && cmd_ready && !flush) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pop", int'(cmd), -1);
            end else begin
               e = exp_q.pop_front();
               chk("pop_cmd", int'(cmd), e);
            end
         end
      end
   end

   initial begin
      rst       = 1'b0;
      keys      = 5'b00100;
      flush     = 1'b0;
      cmd_ready = 1'b0;
      #12;
      chk("rst_count", int'(count), 0);
      chk("rst_valid", int'(cmd_valid), 0);
      chk("rst_cmd", int'(cmd), 0);
      chk("rst_ovf", int'(overflow), 0);

      // Held key across reset release must not generate a command.
      tick();
      rst = 1'b1;
      repeat (10) tick();
      chk("held_valid", int'(cmd_valid), 0);
      chk("held_count", int'(count), 0);
      keys[2] = 1'b0;
      tick();
      press(2, 1'b1);
      chk("repress_valid", int'(cmd_valid), 1);
      chk("repress_cmd", int'(cmd), 2);
      chk("repress_count", int'(count), 1);
      drain(1);
      chk("repress_drained", int'(count), 0);

      // Single press held off by cmd_ready=0.
      press(0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         chk("hold_valid", int'(cmd_valid), 1);
         chk("hold_cmd", int'(cmd), 0);
         tick();
      end
      chk("hold_count", int'(count), 1);
      drain(1);
      chk("single_valid", int'(cmd_valid), 0);
      chk("single_count", int'(count), 0);

      // Simultaneous rises: only down is taken.
      keys = 5'b11010;
      exp_q.push_back(1);
      tick();
      chk("prio_count", int'(count), 1);
      chk("prio_cmd", int'(cmd), 1);
      chk("prio_ovf", int'(overflow), 0);
      keys = 5'b00000;
      tick();
      chk("prio_ovf2", int'(overflow), 0);
      chk("prio_count2", int'(count), 1);
      drain(1);
      chk("prio_drained", int'(count), 0);

      // Fill to DEPTH, fifth press overflows.
      for (int k = 0; k < 4; k++) begin
         press(k, 1'b1);
         tick();
      end
      chk("full_count", int'(count), 4);
      chk("full_ovf_before", int'(overflow), 0);
      press(4, 1'b0);
      chk("ovf_pulse", int'(overflow), 1);
      chk("ovf_count", int'(count), 4);
      tick();
      chk("ovf_cleared", int'(overflow), 0);
      drain(4);
      chk("full_drained", int'(count), 0);
      chk("full_drained_valid", int'(cmd_valid), 0);

      // Full with simultaneous pop: push accepted, Enter comes out last.
      for (int k = 0; k < 4; k++) begin
         press(k, 1'b1);
         tick();
      end
      cmd_ready = 1'b1;
      press(4, 1'b1);
      cmd_ready = 1'b0;
      chk("fullpop_count", int'(count), 4);
      chk("fullpop_ovf", int'(overflow), 0);
      tick();
      chk("fullpop_ovf2", int'(overflow), 0);
      drain(4);
      chk("fullpop_drained", int'(count), 0);

      // Flush with simultaneous pop and press.
      press(0, 1'b1);
      press(2, 1'b1);
      press(3, 1'b1);
      chk("preflush_count", int'(count), 3);
      flush     = 1'b1;
      cmd_ready = 1'b1;
      keys[1]   = 1'b1;
      tick();
      exp_q.delete();
      flush     = 1'b0;
      cmd_ready = 1'b0;
      keys[1]   = 1'b0;
      chk("flush_count", int'(count), 0);
      chk("flush_valid", int'(cmd_valid), 0);
      chk("flush_ovf", int'(overflow), 0);
      tick();
      chk("flush_count2", int'(count), 0);

      // Press/pop pairs walk the pointers through several wraps.
      for (int i = 0; i < 10; i++) begin
         press(i % 5, 1'b1);
         chk("wrap_count", int'(count), 1);
         chk("wrap_cmd", int'(cmd), i % 5);
         drain(1);
      end
      chk("wrap_final_count", int'(count), 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
